pa_rst_seq_ctrl: RTL



---
 rtl/pa_rst_seq_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pa_rst_seq_ctrl.sv
// CPU subsystem reset sequencer: orders core/bus/debug domain resets after POR or a
// reset request, records the reset cause, and applies the scan-mode reset override.
module pa_rst_seq_ctrl #(
   parameter int HOLD_CYC  = 16,
   parameter int STAGE_GAP = 4
) (
   input  logic       forever_cpuclk,
   input  logic       cpu_rst,
   input  logic       sw_rst_req,
   input  logic       dbg_rst_req,
   input  logic       wdt_rst_req,
   input  logic       cause_clr,
   input  logic       pad_yy_scan_mode,
   input  logic       pad_yy_scan_rst_b,
   output logic       core_rst_b,
   output logic       bus_rst_b,
   output logic       dbg_rst_b,
   output logic       seq_busy,
   output logic [3:0] rst_cause
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      ASRT_CORE = 2'd1,
      HOLD      = 2'd2,
      REL_BUS   = 2'd3
   } seq_state_t;

   localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

   seq_state_t state_r;
   logic [7:0] cnt_r;
   logic [3:0] cause_r;
   logic       dbg_scope_r;
   logic       core_rst_b_r;
   logic       bus_rst_b_r;
   logic       dbg_rst_b_r;
   logic       seq_busy_r;
   logic       any_req_s;

   assign any_req_s = sw_rst_req | dbg_rst_req | wdt_rst_req;

   // Sequencer FSM; the domain reset registers are loaded with the decode of the state being entered
   always_ff @(posedge forever_cpuclk) begin
      if (cpu_rst) begin
         state_r      <= HOLD;
         cnt_r        <= 8'd0;
         cause_r      <= 4'b0001;
         dbg_scope_r  <= 1'b1;
         core_rst_b_r <= 1'b0;
         bus_rst_b_r  <= 1'b0;
         dbg_rst_b_r  <= 1'b0;
         seq_busy_r   <= 1'b1;
      end else begin
         case (state_r)
            RUN: begin
               if (any_req_s) begin
                  state_r      <= ASRT_CORE;
                  cnt_r        <= 8'd0;
                  cause_r      <= {wdt_rst_req, dbg_rst_req, sw_rst_req, 1'b0};
                  dbg_scope_r  <= wdt_rst_req;
                  core_rst_b_r <= 1'b0;
                  bus_rst_b_r  <= 1'b1;
                  dbg_rst_b_r  <= 1'b1;
                  seq_busy_r   <= 1'b1;
               end else if (cause_clr) begin
                  cause_r <= 4'b0000;
               end else begin
                  cause_r <= cause_r;
               end
            end
            ASRT_CORE: begin
               if (cnt_r == GAP_LAST) begin
                  state_r     <= HOLD;
                  cnt_r       <= 8'd0;
                  bus_rst_b_r <= 1'b0;
                  dbg_rst_b_r <= ~dbg_scope_r;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  state_r     <= REL_BUS;
                  cnt_r       <= 8'd0;
                  bus_rst_b_r <= 1'b1;
                  dbg_rst_b_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            REL_BUS: begin
               if (cnt_r == GAP_LAST) begin
                  state_r      <= RUN;
                  cnt_r        <= 8'd0;
                  core_rst_b_r <= 1'b1;
                  seq_busy_r   <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            default: begin
               state_r      <= HOLD;
               cnt_r        <= 8'd0;
               cause_r      <= 4'b0001;
               dbg_scope_r  <= 1'b1;
               core_rst_b_r <= 1'b0;
               bus_rst_b_r  <= 1'b0;
               dbg_rst_b_r  <= 1'b0;
               seq_busy_r   <= 1'b1;
            end
         endcase
      end
   end

   // Scan mode hands every domain reset directly to the scan reset pad
   assign core_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : core_rst_b_r;
   assign bus_rst_b  = pad_yy_scan_mode ? pad_yy_scan_rst_b : bus_rst_b_r;
   assign dbg_rst_b  = pad_yy_scan_mode ? pad_yy_scan_rst_b : dbg_rst_b_r;
   assign seq_busy   = seq_busy_r;
   assign rst_cause  = cause_r;

endmodule
